// File: rtl/alu_acc_seq.sv
// Accumulator/sequencer around the combinational 4-bit ALU.
// Owns acc, operand and repeat state plus the command handshake.
module alu_acc_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [1:0]       alu_f,
    input  logic [WIDTH-1:0] alu_xy,
    output logic [WIDTH-1:0] acc,
    output logic             acc_zero,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] F_ZERO = 2'd3;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             accept;
    logic             last_pass;

    // Handshake and pass bookkeeping derived from the current state
    always_comb begin
        accept    = 1'b0;
        last_pass = 1'b0;
        accept    = cmd_valid && (state_q == IDLE);
        last_pass = (rem_q == '0);
    end

    // Next-state, datapath update and Moore-style outputs
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        y_d       = y_q;
        op_d      = op_q;
        rem_d     = rem_q;
        cmd_ready = 1'b0;
        alu_f     = F_ZERO;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    y_d = cmd_y;
                    if (cmd_load) begin
                        acc_d   = cmd_y;
                        state_d = DONE;
                    end else begin
                        op_d    = cmd_op;
                        rem_d   = cmd_rep;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_f = op_q;
                acc_d = alu_xy;
                // Stop on zero rather than decrementing, so rem never wraps
                if (last_pass) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            op_q    <= F_ZERO;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    // ALU operand buses and accumulator observation
    always_comb begin
        alu_x    = acc_q;
        alu_y    = y_q;
        acc      = acc_q;
        acc_zero = (acc_q == '0);
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with a behavioural ALU on the bus.
// Outputs are sampled on the falling clock edge.
module tb_alu_acc_seq;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [1:0] cmd_op;
    logic [3:0] cmd_y;
    logic [3:0] cmd_rep;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [1:0] alu_f;
    logic [3:0] alu_xy;
    logic [3:0] acc;
    logic       acc_zero;
    logic       done;

    int checks = 0;
    int errors = 0;

    alu_acc_seq #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_y     (cmd_y),
        .cmd_rep   (cmd_rep),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_f     (alu_f),
        .alu_xy    (alu_xy),
        .acc       (acc),
        .acc_zero  (acc_zero),
        .done      (done)
    );

    // Behavioural ALU: add, sub, mul2, zero
    always_comb begin
        alu_xy = 4'd0;
        unique case (alu_f)
            2'd0:    alu_xy = alu_x + alu_y;
            2'd1:    alu_xy = alu_x - alu_y;
            2'd2:    alu_xy = {alu_x[2:0], 1'b0};
            default: alu_xy = 4'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a command at a falling edge, wait for acceptance; returns in cycle 1
    task automatic issue(input logic ld, input logic [1:0] op,
                         input logic [3:0] y, input logic [3:0] rep,
                         input bit hold);
        int n;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_y     = y;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v, input string tag);
        issue(1'b1, 2'd0, v, 4'd0, 1'b0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_acc"}, 32'(acc), 32'(v));
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 2'd0;
        cmd_y     = 4'd0;
        cmd_rep   = 4'd0;

        // 1: reset with clock stopped, then clocked reset
        #3 rst_n = 1'b0;
        #1;
        check("rst_stop_acc", 32'(acc), 32'd0);
        check("rst_stop_zero", 32'(acc_zero), 32'd1);
        check("rst_stop_ready", 32'(cmd_ready), 32'd1);
        check("rst_stop_done", 32'(done), 32'd0);
        check("rst_stop_f", 32'(alu_f), 32'd3);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_zero", 32'(acc_zero), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_f", 32'(alu_f), 32'd3);
        check("rst_y", 32'(alu_y), 32'd0);

        // 2: load 5, add 3 once
        do_load(4'd5, "s2_ld");
        issue(1'b0, 2'd0, 4'd3, 4'd0, 1'b0);
        check("s2_c1_f", 32'(alu_f), 32'd0);
        check("s2_c1_y", 32'(alu_y), 32'd3);
        check("s2_c1_x", 32'(alu_x), 32'd5);
        check("s2_c1_done", 32'(done), 32'd0);
        check("s2_c1_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("s2_c2_acc", 32'(acc), 32'd8);
        check("s2_c2_done", 32'(done), 32'd1);
        check("s2_c2_ready", 32'(cmd_ready), 32'd0);
        check("s2_c2_f", 32'(alu_f), 32'd3);
        @(negedge clk);
        check("s2_c3_ready", 32'(cmd_ready), 32'd1);
        check("s2_c3_done", 32'(done), 32'd0);

        // 3: load 1, mul2 five times: 2,4,8,0,0
        do_load(4'd1, "s3_ld");
        issue(1'b0, 2'd2, 4'd0, 4'd4, 1'b0);
        pulses = 0;
        check("s3_c1_acc", 32'(acc), 32'd1);
        @(negedge clk);
        check("s3_c2_acc", 32'(acc), 32'd2);
        @(negedge clk);
        check("s3_c3_acc", 32'(acc), 32'd4);
        @(negedge clk);
        check("s3_c4_acc", 32'(acc), 32'd8);
        @(negedge clk);
        check("s3_c5_acc", 32'(acc), 32'd0);
        check("s3_c5_done", 32'(done), 32'd0);
        @(negedge clk);
        check("s3_c6_acc", 32'(acc), 32'd0);
        check("s3_c6_zero", 32'(acc_zero), 32'd1);
        check("s3_c6_done", 32'(done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("s3_pulses", 32'(pulses), 32'd1);

        // 4: load 2, sub 3 wraps to F
        do_load(4'd2, "s4_ld");
        issue(1'b0, 2'd1, 4'd3, 4'd0, 1'b0);
        @(negedge clk);
        check("s4_acc", 32'(acc), 32'hF);
        check("s4_zero", 32'(acc_zero), 32'd0);
        check("s4_done", 32'(done), 32'd1);
        @(negedge clk);

        // 5: load 0, add 1 sixteen times with cmd_valid held
        do_load(4'd0, "s5_ld");
        issue(1'b0, 2'd0, 4'd1, 4'd15, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            check($sformatf("s5_c%0d_acc", k), 32'(acc), 32'((k - 1) % 16));
            check($sformatf("s5_c%0d_done", k), 32'(done),
                  (k == 17) ? 32'd1 : 32'd0);
            check($sformatf("s5_c%0d_ready", k), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check("s5_c18_ready", 32'(cmd_ready), 32'd1);
        check("s5_c18_acc", 32'(acc), 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);

        // 6: same command, async reset in EXEC cycle 7
        do_load(4'd0, "s6_ld");
        issue(1'b0, 2'd0, 4'd1, 4'd15, 1'b0);
        repeat (6) @(negedge clk);
        check("s6_c7_acc", 32'(acc), 32'd6);
        check("s6_c7_f", 32'(alu_f), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_acc", 32'(acc), 32'd0);
        check("s6_rst_ready", 32'(cmd_ready), 32'd1);
        check("s6_rst_f", 32'(alu_f), 32'd3);
        check("s6_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("s6_no_done", 32'(pulses), 32'd0);
        check("s6_idle_acc", 32'(acc), 32'd0);
        do_load(4'd9, "s6_ld9");
        check("s6_ld9_ready", 32'(cmd_ready), 32'd1);
        check("s6_ld9_acc", 32'(acc), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Accumulator/sequencer stage driving the 4-bit ALU's operand buses and capturing its result. It accepts commands over a valid/ready handshake. Each command either loads the accumulator directly or applies one ALU operation to the accumulator (cmd_rep+1) times. The ALU stays purely combinational; this block owns all state, latency and handshaking around it.

Parameters:
WIDTH, 4, datapath width; fixed at 4 to match the ALU, other values unsupported.
CNT_W, 4, width of repeat count cmd_rep and internal remaining-count register.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_load  in  1  1 = load acc with cmd_y; 0 = execute cmd_op
cmd_op  in  2  ALU function, F encoding: 0 add, 1 sub, 2 mul2, 3 zero
cmd_y  in  WIDTH  Y operand (or load value)
cmd_rep  in  CNT_W  number of extra applications (total = cmd_rep+1)
alu_x  out  WIDTH  to ALU X; always equals acc
alu_y  out  WIDTH  to ALU Y; registered y_q
alu_f  out  2  to ALU F
alu_xy  in  WIDTH  ALU result XY
acc  out  WIDTH  accumulator value
acc_zero  out  1  combinational (acc == 0)
done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, y_q=0, op_q=3, rem=0, done=0. So cmd_ready=1, alu_f=3, acc_zero=1. Takes effect immediately, including mid-EXEC. An in-flight command is discarded with no done pulse.
- Accept = cmd_valid & cmd_ready. cmd_ready=1 only in IDLE, derived combinationally from state. cmd_valid while not ready is ignored, and upstream must hold it.
- States: IDLE, EXEC, DONE.
- IDLE, accept with cmd_load=1: acc<=cmd_y and y_q<=cmd_y at that edge. Go to DONE.
- IDLE, accept with cmd_load=0: op_q<=cmd_op, y_q<=cmd_y, rem<=cmd_rep. Go to EXEC.
- EXEC: alu_f=op_q. Each cycle acc<=alu_xy. If rem==0 go to DONE, else rem<=rem-1 and stay in EXEC. Exactly cmd_rep+1 EXEC cycles.
- DONE: done=1 for this cycle only, cmd_ready=0, then go to IDLE.
- alu_f=3 (zero op) in IDLE and DONE, so ALU output is deterministic when idle.
- Latency, execute command accepted at edge 0: EXEC occupies cycles 1..R+1 (R=cmd_rep), done high in cycle R+2, cmd_ready high again in cycle R+3.
- Latency, load command: done high in cycle 1, ready in cycle 2.
- Arithmetic: all results are modulo 2^WIDTH, produced by the ALU. This block captures alu_xy unmodified and performs no overflow detection.
- cmd_rep=all-ones: 2^CNT_W applications. The counter must not underflow or wrap into an extra pass.
- acc is observable every cycle. Intermediate EXEC values are visible on acc.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release -> acc=0, acc_zero=1, cmd_ready=1, done=0, alu_f=3. Reset while clk is stopped also clears outputs.
2. Load 5, then execute add y=3 rep=0 -> one EXEC cycle, acc=8, done pulses 2 cycles after accept, cmd_ready returns in cycle 3.
3. Load 1, then execute mul2 rep=4 -> acc sequence 2,4,8,0,0 over 5 EXEC cycles, final acc_zero=1, single done pulse.
4. Load 2, then execute sub y=3 rep=0 -> acc=4'hF (wrap-around), acc_zero=0.
5. Load 0, then execute add y=1 rep=15 -> 16 EXEC cycles, acc passes 1..15, final acc=0, done in cycle 17. Hold cmd_valid=1 throughout; nothing further is accepted until cycle 18.
6. Repeat scenario 5 and drop rst_n during EXEC cycle 7 -> state IDLE and acc=0 immediately, no done pulse. The next accepted load 9 completes normally with acc=9.
